multiplier_cp: RTL and testbench
================================

Name: multiplier_cp

Overview:
- Control path (FSM) of the iterative RV32M multiplier accelerator.
- Sequences one multiply operation through a fixed 6-state schedule: operand load, four partial-product accumulation steps, completion.
- Drives register enables, operand-B mux, sign-extension control, per-sub-multiplier shift amounts, operand-B rotate enable and a done flag to the datapath.
- Purely Moore except sig_ctrl_B_o, which also depends on signed_B_i.

Parameters:
- none

Ports:
- clk_i  input  1  system clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- mult_en_i  input  1  multiplier enable / start request
- signed_B_i  input  1  1 = operand B is signed and needs sign extension
- reg_A_en_o  output  1  load enable, operand A register
- reg_B_en_o  output  1  load enable, operand B register
- AC_en_o  output  1  result accumulator enable
- mux_B_sel_o  output  1  operand-B mux select (0 = external operand, 1 = rotated feedback)
- sig_ctrl_B_o  output  4  one-hot sign-extension control for operand-B byte lanes
- shift_0_o  output  3  shift amount, sub-multiplier 0
- shift_1_o  output  3  shift amount, sub-multiplier 1
- shift_2_o  output  3  shift amount, sub-multiplier 2
- shift_3_o  output  3  shift amount, sub-multiplier 3
- rol_en_o  output  1  rotate-left enable, operand-B register
- done_o  output  1  operation complete

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk_i / rst_i.
- Reset action: rst_i=1 at a rising edge forces state to INIT. This overrides any other transition, including mid-operation.
- States: INIT, MULT_1, MULT_2, MULT_3, MULT_4, DONE (3-bit encoding).
- Transitions, one per rising edge:
  - INIT -> MULT_1 if mult_en_i=1, else stay in INIT.
  - MULT_1 -> MULT_2 -> MULT_3 -> MULT_4 -> DONE unconditionally.
  - DONE stays in DONE while mult_en_i=1; DONE -> INIT when mult_en_i=0.
- Latency: with mult_en_i held at 1, DONE is reached 5 rising edges after INIT. done_o stays high from then on.
- Outputs are decoded from state only, except sig_ctrl_B_o:
  - INIT: regA=1 regB=1 AC=0 muxB=0 sigB=0000 shifts 0/0/0/0 rol=0 done=0.
  - MULT_1: regA=0 regB=1 AC=1 muxB=1 sigB=(signed_B_i?1000:0000) shifts 0/2/4/6 rol=1 done=0.
  - MULT_2: regA=0 regB=1 AC=1 muxB=1 sigB=(signed_B_i?0001:0000) shifts 3/1/3/5 rol=1 done=0.
  - MULT_3: regA=0 regB=1 AC=1 muxB=1 sigB=(signed_B_i?0010:0000) shifts 2/4/2/4 rol=1 done=0.
  - MULT_4: regA=0 regB=1 AC=1 muxB=1 sigB=(signed_B_i?0100:0000) shifts 1/3/5/3 rol=1 done=0.
  - DONE: all outputs 0 except done=1.
  - Shift values are listed as shift_0/shift_1/shift_2/shift_3.
- Output values after reset are the INIT row.
- signed_B_i is sampled combinationally; changing it mid-operation affects only sig_ctrl_B_o in the current state.
- Unreachable state encodings decode to the INIT outputs and transition to INIT.
- All outputs are fully defined (no X) in every state.

Test Plan:
- Unsigned run: signed_B_i=0, mult_en_i=1, pulse reset → successive cycles give INIT, MULT_1..MULT_4, DONE.
  - Each state's outputs match its row above, with sigB=0000 throughout.
- Signed run: signed_B_i=1, same stimulus → sigB sequence 0000, 1000, 0001, 0010, 0100, 0000; all other outputs identical to the unsigned run.
- Hold/idle: mult_en_i=0 after reset → FSM stays in INIT for 5+ cycles with INIT outputs.
  - Assert mult_en_i → MULT_1 on the next edge (shifts 0/2/4/6).
- DONE handling: keep mult_en_i=1 in DONE → done_o stays 1.
  - Drop mult_en_i → INIT next edge (regA=regB=1, done=0).
- Reset mid-operation: assert rst_i in MULT_2 → INIT outputs after that edge.
  - Normal sequence restarts afterwards.
- Toggle signed_B_i during MULT_3 → sig_ctrl_B_o switches between 0010 and 0000 with no state change.

Source files
------------

// File: rtl/multiplier_cp.sv
// Control path of the iterative RV32M multiplier: sequences operand load,
// four partial-product accumulation steps and completion.
//
// state  | meaning
// INIT   | idle, operand A/B registers loading, waiting for mult_en_i
// MULT_1 | accumulate partial products, byte lane 3 sign control
// MULT_2 | accumulate partial products, byte lane 0 sign control
// MULT_3 | accumulate partial products, byte lane 1 sign control
// MULT_4 | accumulate partial products, byte lane 2 sign control
// DONE   | result valid, held until mult_en_i drops
module multiplier_cp (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mult_en_i,
  input  logic       signed_B_i,
  output logic       reg_A_en_o,
  output logic       reg_B_en_o,
  output logic       AC_en_o,
  output logic       mux_B_sel_o,
  output logic [3:0] sig_ctrl_B_o,
  output logic [2:0] shift_0_o,
  output logic [2:0] shift_1_o,
  output logic [2:0] shift_2_o,
  output logic [2:0] shift_3_o,
  output logic       rol_en_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    MULT_1 = 3'd1,
    MULT_2 = 3'd2,
    MULT_3 = 3'd3,
    MULT_4 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = INIT;
    reg_A_en_o   = 1'b0;
    reg_B_en_o   = 1'b0;
    AC_en_o      = 1'b0;
    mux_B_sel_o  = 1'b0;
    sig_ctrl_B_o = 4'b0000;
    shift_0_o    = 3'd0;
    shift_1_o    = 3'd0;
    shift_2_o    = 3'd0;
    shift_3_o    = 3'd0;
    rol_en_o     = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      MULT_1: begin
        state_d      = MULT_2;
        reg_B_en_o   = 1'b1;
        AC_en_o      = 1'b1;
        mux_B_sel_o  = 1'b1;
        sig_ctrl_B_o = signed_B_i ? 4'b1000 : 4'b0000;
        shift_0_o    = 3'd0;
        shift_1_o    = 3'd2;
        shift_2_o    = 3'd4;
        shift_3_o    = 3'd6;
        rol_en_o     = 1'b1;
      end
      MULT_2: begin
        state_d      = MULT_3;
        reg_B_en_o   = 1'b1;
        AC_en_o      = 1'b1;
        mux_B_sel_o  = 1'b1;
        sig_ctrl_B_o = signed_B_i ? 4'b0001 : 4'b0000;
        shift_0_o    = 3'd3;
        shift_1_o    = 3'd1;
        shift_2_o    = 3'd3;
        shift_3_o    = 3'd5;
        rol_en_o     = 1'b1;
      end
      MULT_3: begin
        state_d      = MULT_4;
        reg_B_en_o   = 1'b1;
        AC_en_o      = 1'b1;
        mux_B_sel_o  = 1'b1;
        sig_ctrl_B_o = signed_B_i ? 4'b0010 : 4'b0000;
        shift_0_o    = 3'd2;
        shift_1_o    = 3'd4;
        shift_2_o    = 3'd2;
        shift_3_o    = 3'd4;
        rol_en_o     = 1'b1;
      end
      MULT_4: begin
        state_d      = DONE;
        reg_B_en_o   = 1'b1;
        AC_en_o      = 1'b1;
        mux_B_sel_o  = 1'b1;
        sig_ctrl_B_o = signed_B_i ? 4'b0100 : 4'b0000;
        shift_0_o    = 3'd1;
        shift_1_o    = 3'd3;
        shift_2_o    = 3'd5;
        shift_3_o    = 3'd3;
        rol_en_o     = 1'b1;
      end
      DONE: begin
        state_d = mult_en_i ? DONE : INIT;
        done_o  = 1'b1;
      end
      INIT: begin
        state_d    = mult_en_i ? MULT_1 : INIT;
        reg_A_en_o = 1'b1;
        reg_B_en_o = 1'b1;
      end
      // Unused encodings fall back to idle outputs and recover to INIT.
      default: begin
        state_d    = INIT;
        reg_A_en_o = 1'b1;
        reg_B_en_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_cp.sv
// Directed and randomized checks of multiplier_cp against a schedule-step
// reference model with a per-step output table.
module tb_multiplier_cp;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       mult_en_i;
  logic       signed_B_i;
  logic       reg_A_en_o;
  logic       reg_B_en_o;
  logic       AC_en_o;
  logic       mux_B_sel_o;
  logic [3:0] sig_ctrl_B_o;
  logic [2:0] shift_0_o;
  logic [2:0] shift_1_o;
  logic [2:0] shift_2_o;
  logic [2:0] shift_3_o;
  logic       rol_en_o;
  logic       done_o;

  int n_compared   = 0;
  int n_mismatched = 0;
  int m_step       = 0;

  multiplier_cp dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mult_en_i   (mult_en_i),
    .signed_B_i  (signed_B_i),
    .reg_A_en_o  (reg_A_en_o),
    .reg_B_en_o  (reg_B_en_o),
    .AC_en_o     (AC_en_o),
    .mux_B_sel_o (mux_B_sel_o),
    .sig_ctrl_B_o(sig_ctrl_B_o),
    .shift_0_o   (shift_0_o),
    .shift_1_o   (shift_1_o),
    .shift_2_o   (shift_2_o),
    .shift_3_o   (shift_3_o),
    .rol_en_o    (rol_en_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Schedule step 0 = idle, 1..4 = accumulation steps, 5 = complete.
  function automatic logic [21:0] expected_outputs(int step, logic sgn);
    logic       ra, rb, ac, mb, rol, dn;
    logic [3:0] sig;
    int         sh[4];
    int         lane;
    ra = 0; rb = 0; ac = 0; mb = 0; rol = 0; dn = 0; sig = 4'b0000;
    sh = '{0, 0, 0, 0};
    if (step == 0) begin
      ra = 1; rb = 1;
    end else if (step == 5) begin
      dn = 1;
    end else begin
      rb = 1; ac = 1; mb = 1; rol = 1;
      lane = (step + 2) % 4;
      if (sgn) sig = 4'(1 << lane);
      case (step)
        1: sh = '{0, 2, 4, 6};
        2: sh = '{3, 1, 3, 5};
        3: sh = '{2, 4, 2, 4};
        default: sh = '{1, 3, 5, 3};
      endcase
    end
    return {ra, rb, ac, mb, sig, 3'(sh[0]), 3'(sh[1]), 3'(sh[2]), 3'(sh[3]), rol, dn};
  endfunction

  function automatic int next_step(int step, logic rst, logic en);
    if (rst) return 0;
    if (step == 0) return en ? 1 : 0;
    if (step == 5) return en ? 5 : 0;
    return step + 1;
  endfunction

  task automatic check(string tag);
    logic [21:0] obs;
    logic [21:0] exp;
    obs = {reg_A_en_o, reg_B_en_o, AC_en_o, mux_B_sel_o, sig_ctrl_B_o,
           shift_0_o, shift_1_o, shift_2_o, shift_3_o, rol_en_o, done_o};
    exp = expected_outputs(m_step, signed_B_i);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, m_step, obs, exp);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk_i);
    m_step = next_step(m_step, rst_i, mult_en_i);
    #1;
    check(tag);
  endtask

  initial begin
    rst_i = 1; mult_en_i = 1; signed_B_i = 0;
    tick("reset");

    // Unsigned run to completion, then hold and release DONE.
    rst_i = 0;
    for (int i = 0; i < 5; i++) tick("unsigned_seq");
    tick("done_hold");
    tick("done_hold");
    mult_en_i = 0;
    tick("done_release");

    // Signed run.
    rst_i = 1; mult_en_i = 1; signed_B_i = 1;
    tick("signed_reset");
    rst_i = 0;
    for (int i = 0; i < 5; i++) tick("signed_seq");

    // Idle with enable low.
    rst_i = 1; mult_en_i = 0; signed_B_i = 0;
    tick("idle_reset");
    rst_i = 0;
    for (int i = 0; i < 6; i++) tick("idle_hold");
    mult_en_i = 1;
    tick("start_mult1");

    // Reset while in MULT_2, then restart.
    tick("mult2");
    rst_i = 1;
    tick("reset_mid_op");
    rst_i = 0;
    tick("restart_mult1");
    tick("restart_mult2");
    tick("restart_mult3");

    // signed_B_i toggled combinationally in MULT_3.
    signed_B_i = 1; #1; check("toggle_sig_on");
    signed_B_i = 0; #1; check("toggle_sig_off");
    signed_B_i = 1; #1; check("toggle_sig_on2");
    tick("after_toggle_mult4");
    tick("after_toggle_done");

    // Random stimulus.
    for (int i = 0; i < 400; i++) begin
      rst_i      = ($urandom_range(0, 19) == 0);
      mult_en_i  = ($urandom_range(0, 3) != 0);
      signed_B_i = 1'($urandom_range(0, 1));
      #1; check("random_comb");
      tick("random_seq");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
